// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: opcode and mult/div sequencer encodings.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_MULT  = 4'b0010,
        ALU_DIVU  = 4'b0011,
        ALU_SLL   = 4'b0100,
        ALU_SRL   = 4'b0101,
        ALU_AND   = 4'b0110,
        ALU_OR    = 4'b0111,
        ALU_XOR   = 4'b1000,
        ALU_NOR   = 4'b1001,
        ALU_PASSA = 4'b1010,
        ALU_NAND  = 4'b1011,
        ALU_NOTA  = 4'b1100,
        ALU_SLT   = 4'b1101,
        ALU_SGT   = 4'b1110,
        ALU_MFHI  = 4'b1111
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIN  = 2'd3
    } md_state_t;

    localparam alu_op_t OP_MULT = ALU_MULT;
    localparam alu_op_t OP_DIVU = ALU_DIVU;
    localparam alu_op_t OP_MFHI = ALU_MFHI;

    // True when an accepted op needs the iterative datapath (a divide by zero
    // is resolved immediately instead).
    function automatic logic starts_iter(input alu_op_t op, input logic divisor_zero);
        return (op == OP_MULT) || ((op == OP_DIVU) && !divisor_zero);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative datapath: unsigned shift-add multiply and restoring divide,
// one bit per cycle, WIDTH iterations after each load.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             step_done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int             CNT_W   = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // acc_q holds {upper, lower}: product-high/multiplier for mult,
    // partial-remainder/quotient for divide.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q;      // multiplicand (mult) or divisor (divu)
    logic               is_div_q;
    logic [CNT_W-1:0]   cnt_q;       // iterations completed; CNT_END means idle
    logic               running;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     trial;

    assign running = (cnt_q != CNT_END);

    // One iteration of whichever algorithm is loaded.
    always_comb begin
        // NOTE: acc_d is assigned on every path through this block, so no latch is inferred.
        add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        trial   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opnd_q};
        if (is_div_q) begin
            if (trial[WIDTH]) begin
                // Borrow: divisor does not fit, keep the shifted remainder, quotient bit 0.
                acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
            end else begin
                acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end
        end else begin
            // Conditionally add multiplicand to the upper half, then shift right with carry.
            acc_d = {add_sum, acc_q[WIDTH-1:1]};
        end
    end

    // Operand capture on load, then one iteration per cycle until WIDTH are done.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
        if (reset) begin
            acc_q    <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            cnt_q    <= CNT_END;
        end else if (load) begin
            acc_q    <= {{WIDTH{1'b0}}, (is_div ? a : b)};
            opnd_q   <= is_div ? b : a;
            is_div_q <= is_div;
            cnt_q    <= '0;
        end else if (running) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + CNT_ONE;
        end
    end

    // High during the cycle whose closing edge performs the final iteration.
    assign step_done = running && (cnt_q == (CNT_END - CNT_ONE));
    assign hi_out    = acc_q[2*WIDTH-1:WIDTH];
    assign lo_out    = acc_q[WIDTH-1:0];

endmodule

// File: rtl/alu_muldiv.sv
// Multi-cycle integer ALU: single-cycle ops with registered result, plus
// iterative unsigned mult/divu writing HI/LO, with a start/busy/done handshake.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    md_state_t        state_q, state_d;
    alu_op_t          op_e;
    logic             accept;
    logic             b_zero;
    logic             iter_load;
    logic             step_done;
    logic             fin;
    logic [WIDTH-1:0] iter_hi, iter_lo;
    logic [WIDTH-1:0] alu_y;
    logic [SHAMT_W-1:0] shamt;

    logic [WIDTH-1:0] result_q, hi_q, lo_q;
    logic             zero_q, done_q, dbz_q;

    assign op_e      = alu_op_t'(op);
    assign accept    = start && (state_q == IDLE);
    assign b_zero    = (b == '0);
    assign iter_load = accept && starts_iter(op_e, b_zero);
    assign shamt     = b[SHAMT_W-1:0];

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk       (clk),
        .reset     (reset),
        .load      (iter_load),
        .is_div    (op_e == OP_DIVU),
        .a         (a),
        .b         (b),
        .step_done (step_done),
        .hi_out    (iter_hi),
        .lo_out    (iter_lo)
    );

    // Sequencer state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Sequencer next-state: IDLE -> MUL/DIV -> FIN -> IDLE; start is ignored outside IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (iter_load) state_d = (op_e == OP_DIVU) ? DIV : MUL;
            MUL, DIV: if (step_done) state_d = FIN;
            FIN:      state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Sequencer outputs: busy covers the iterations and the FIN write-back cycle.
    always_comb begin
        busy = (state_q != IDLE);
        fin  = (state_q == FIN);
    end

    // Single-cycle operation mux; mult/divu results come from the iterator instead.
    always_comb begin
        alu_y = '0;
        case (op_e)
            ALU_ADD:   alu_y = a + b;
            ALU_SUB:   alu_y = a + ~b + {{(WIDTH-1){1'b0}}, 1'b1};
            ALU_SLL:   alu_y = a << shamt;
            ALU_SRL:   alu_y = a >> shamt;
            ALU_AND:   alu_y = a & b;
            ALU_OR:    alu_y = a | b;
            ALU_XOR:   alu_y = a ^ b;
            ALU_NOR:   alu_y = ~(a | b);
            ALU_PASSA: alu_y = a;
            ALU_NAND:  alu_y = ~(a & b);
            ALU_NOTA:  alu_y = ~a;
            ALU_SLT:   alu_y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SGT:   alu_y = {{(WIDTH-1){1'b0}}, ($signed(a) > $signed(b))};
            ALU_MFHI:  alu_y = hi_q;
            default:   alu_y = '0;
        endcase
    end

    // Architectural output registers: result/zero/HI/LO/div_by_zero and the done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q <= '0;
            zero_q   <= 1'b1;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (fin) begin
                hi_q     <= iter_hi;
                lo_q     <= iter_lo;
                result_q <= iter_lo;
                zero_q   <= (iter_lo == '0);
                done_q   <= 1'b1;
            end else if (accept) begin
                dbz_q <= 1'b0;
                if ((op_e == OP_DIVU) && b_zero) begin
                    hi_q     <= a;
                    lo_q     <= '1;
                    result_q <= '1;
                    zero_q   <= 1'b0;
                    dbz_q    <= 1'b1;
                    done_q   <= 1'b1;
                end else if (!iter_load) begin
                    result_q <= alu_y;
                    zero_q   <= (alu_y == '0);
                    done_q   <= 1'b1;
                end
            end
        end
    end

    assign result      = result_q;
    assign zero        = zero_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: directed cases plus randomized ops
// compared against an arithmetic reference model of the architectural state.
module tb_alu_muldiv;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [3:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done, zero, div_by_zero;
    logic [W-1:0] result, hi, lo;

    int checks   = 0;
    int failures = 0;

    // Reference architectural state.
    logic [W-1:0] m_hi, m_lo, m_res;

    alu_muldiv #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .zero        (zero),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reset is applied away from the clock edge; outputs checked while it is held.
    task automatic reset_check(input string tag);
        #2 reset = 1'b1;
        #1;
        check({tag, ".busy"},   64'(busy),        64'(0));
        check({tag, ".done"},   64'(done),        64'(0));
        check({tag, ".result"}, 64'(result),      64'(0));
        check({tag, ".zero"},   64'(zero),        64'(1));
        check({tag, ".hi"},     64'(hi),          64'(0));
        check({tag, ".lo"},     64'(lo),          64'(0));
        check({tag, ".dbz"},    64'(div_by_zero), 64'(0));
        m_hi = '0; m_lo = '0; m_res = '0;
        #3 reset = 1'b0;
        @(posedge clk); #1;
    endtask

    // Issue one op (caller is at posedge+1), wait for done, compare everything.
    task automatic run_op(input string tag, input logic [3:0] o,
                          input logic [W-1:0] x, input logic [W-1:0] y, input bit poke);
        logic [2*W-1:0] prod;
        logic [W-1:0]   e_res, e_hi, e_lo;
        bit             e_dbz;
        int             e_lat, n, busy_n;
        e_hi = m_hi; e_lo = m_lo; e_dbz = 1'b0; e_lat = 1; e_res = '0;
        case (o)
            4'd0:  e_res = x + y;
            4'd1:  e_res = x - y;
            4'd2:  begin
                       prod  = 64'(x) * 64'(y);
                       e_hi  = prod[2*W-1:W];
                       e_lo  = prod[W-1:0];
                       e_res = e_lo;
                       e_lat = W + 2;
                   end
            4'd3:  if (y == 0) begin
                       e_hi = x; e_lo = '1; e_res = '1; e_dbz = 1'b1;
                   end else begin
                       e_lo = x / y; e_hi = x % y; e_res = e_lo; e_lat = W + 2;
                   end
            4'd4:  e_res = x << (y % W);
            4'd5:  e_res = x >> (y % W);
            4'd6:  e_res = x & y;
            4'd7:  e_res = x | y;
            4'd8:  e_res = x ^ y;
            4'd9:  e_res = ~(x | y);
            4'd10: e_res = x;
            4'd11: e_res = ~(x & y);
            4'd12: e_res = ~x;
            4'd13: e_res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'd14: e_res = ($signed(x) > $signed(y)) ? 32'd1 : 32'd0;
            default: e_res = m_hi;
        endcase

        op = o; a = x; b = y; start = 1'b1;
        n = 0; busy_n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin
                // Operands must already be latched; scramble them.
                start = 1'b0; op = 4'($urandom); a = $urandom; b = $urandom;
            end
            if (poke && n == 10) begin
                start = 1'b1; op = 4'($urandom); a = $urandom; b = $urandom;
            end
            if (poke && n == 11) start = 1'b0;
            if (busy) busy_n++;
        end while (!done && n < 100);
        start = 1'b0;

        check({tag, ".lat"},    64'(n),           64'(e_lat));
        check({tag, ".busy"},   64'(busy_n),      64'(e_lat - 1));
        check({tag, ".result"}, 64'(result),      64'(e_res));
        check({tag, ".zero"},   64'(zero),        64'(e_res == 0));
        check({tag, ".hi"},     64'(hi),          64'(e_hi));
        check({tag, ".lo"},     64'(lo),          64'(e_lo));
        check({tag, ".dbz"},    64'(div_by_zero), 64'(e_dbz));
        m_hi = e_hi; m_lo = e_lo; m_res = e_res;
    endtask

    // One quiet cycle: no repeated done, outputs held.
    task automatic idle_check(input string tag);
        @(posedge clk); #1;
        check({tag, ".nodone"}, 64'(done),   64'(0));
        check({tag, ".hold"},   64'(result), 64'(m_res));
        check({tag, ".hihold"}, 64'(hi),     64'(m_hi));
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 4))
            0:       return W'($urandom_range(0, 15));
            1:       return ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'h8000_0000;
            2:       return '0;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        logic [3:0] r_op;
        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        m_hi = '0; m_lo = '0; m_res = '0;
        repeat (2) @(posedge clk);
        #1;
        check("por.result", 64'(result), 64'(0));
        check("por.zero",   64'(zero),   64'(1));
        check("por.busy",   64'(busy),   64'(0));
        reset = 1'b0;
        @(posedge clk); #1;

        reset_check("rst_idle");
        run_op("add",  4'd0, 32'd7, 32'd5, 1'b0);
        idle_check("add_idle");
        run_op("slt",  4'd13, 32'hFFFF_FFFF, 32'd1, 1'b0);
        run_op("sgt",  4'd14, 32'hFFFF_FFFF, 32'd1, 1'b0);
        run_op("sub0", 4'd1, 32'd5, 32'd5, 1'b0);
        run_op("mult", 4'd2, 32'hFFFF_FFFF, 32'd2, 1'b1);
        idle_check("mult_idle");
        run_op("divu", 4'd3, 32'd100, 32'd7, 1'b1);
        run_op("mfhi", 4'd15, 32'd0, 32'd0, 1'b0);
        run_op("div0", 4'd3, 32'h1234, 32'd0, 1'b0);
        run_op("clr0", 4'd0, 32'd1, 32'd2, 1'b0);
        idle_check("clr_idle");

        // Reset in the middle of a multiply: nothing is written back.
        op = 4'd2; a = 32'd3; b = 32'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        check("midmul.busy", 64'(busy), 64'(1));
        reset_check("rst_mid");
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        check("rst_mid.nodone", 64'(seen), 64'(0));
        check("rst_mid.idle",   64'(busy), 64'(0));
        run_op("mult34", 4'd2, 32'd3, 32'd4, 1'b0);

        // Randomized ops, back-to-back or with a quiet cycle in between.
        for (int i = 0; i < 150; i++) begin
            r_op = 4'($urandom);
            run_op($sformatf("rnd%0d_op%0d", i, r_op), r_op, pick_operand(), pick_operand(),
                   ($urandom_range(0, 1) != 0));
            if ($urandom_range(0, 2) == 0) idle_check($sformatf("rnd%0d_idle", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
